// File: rtl/ad9511_spi_master_pkg.sv
// ad9511_pkg: shared FSM states, AD9511 frame fields and sequencer register addresses
package ad9511_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_GAP} state_t;
   localparam int          RW_BIT    = 23;
   localparam logic [1:0]  W1W0      = 2'b00;
   localparam int          FRAME_LEN = 24;
   localparam int          INSTR_LEN = 16;
   localparam logic [12:0] REG_SERIAL_CFG = 13'h000;
   localparam logic [12:0] REG_CLK_SEL    = 13'h045;
   localparam logic [12:0] REG_FUNCTION   = 13'h058;
   localparam logic [12:0] REG_UPDATE     = 13'h05A;
   function automatic logic [FRAME_LEN-1:0] make_frame(logic rw, logic [12:0] addr, logic [7:0] data);
      return {rw, W1W0, addr, rw ? 8'h00 : data};
   endfunction
endpackage

// File: rtl/ad9511_spi_master_if.sv
// ad9511_spi_master_if: register-access handshake between the configuration sequencer and the SPI master
interface ad9511_spi_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_rw;
   logic [12:0] req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        busy;
   modport master (output req_valid, req_rw, req_addr, req_wdata, input req_ready, rsp_valid, rsp_rdata, busy);
   modport slave  (input req_valid, req_rw, req_addr, req_wdata, output req_ready, rsp_valid, rsp_rdata, busy);
endinterface

// File: rtl/ad9511_spi_master.sv
// ad9511_spi_master: single-byte 3-wire AD9511 register write/read master, all pins registered
module ad9511_spi_master
   import ad9511_pkg::*;
#(
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_IDLE  = 4
) (
   input  logic clock_4MHz125,
   input  logic reset,
   ad9511_spi_master_if.slave bus,
   output logic spi_csb,
   output logic spi_sclk,
   output logic spi_sdio_o,
   output logic spi_sdio_oe,
   input  logic spi_sdio_i
);
   localparam logic [5:0] SETUP_LAST = 6'(CS_SETUP - 1);
   localparam logic [5:0] HOLD_LAST  = 6'(CS_HOLD - 1);
   // the IDLE cycle itself counts toward the CSB-high gap, so GAP is one cycle shorter
   localparam logic [5:0] GAP_LAST   = 6'(CS_IDLE - 2);
   localparam logic [5:0] LAST_BIT   = 6'(2 * FRAME_LEN - 1);
   localparam logic [5:0] OE_OFF     = 6'(2 * INSTR_LEN - 1);
   state_t                 state;
   logic [5:0]             cnt;
   logic [FRAME_LEN-1:0]   sr;
   logic [7:0]             rd;
   logic                   rw;
   always_ff @(posedge clock_4MHz125 or posedge reset)
      if (reset) begin
         state         <= ST_IDLE;
         cnt           <= '0;
         sr            <= '0;
         rd            <= '0;
         rw            <= 1'b0;
         bus.req_ready <= 1'b1;
         bus.busy      <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= 8'h00;
         spi_csb       <= 1'b1;
         spi_sclk      <= 1'b0;
         spi_sdio_o    <= 1'b0;
         spi_sdio_oe   <= 1'b0;
      end else begin
         bus.rsp_valid <= 1'b0;
         cnt           <= cnt + 6'd1;
         case (state)
            ST_IDLE:
               if (bus.req_valid) begin
                  state         <= ST_SETUP;
                  cnt           <= '0;
                  sr            <= make_frame(bus.req_rw, bus.req_addr, bus.req_wdata);
                  rw            <= bus.req_rw;
                  bus.req_ready <= 1'b0;
                  bus.busy      <= 1'b1;
                  spi_csb       <= 1'b0;
                  spi_sdio_oe   <= 1'b1;
                  spi_sdio_o    <= bus.req_rw;
               end
            ST_SETUP:
               if (cnt == SETUP_LAST) begin
                  state <= ST_SHIFT;
                  cnt   <= '0;
               end
            ST_SHIFT: begin
               // cnt[0] is the bit phase; the falling SCLK edge shifts out and samples in
               spi_sclk <= ~cnt[0];
               if (cnt[0]) begin
                  sr         <= {sr[FRAME_LEN-2:0], 1'b0};
                  rd         <= {rd[6:0], spi_sdio_i};
                  spi_sdio_o <= sr[RW_BIT-1];
                  if (rw && cnt == OE_OFF) spi_sdio_oe <= 1'b0;
                  if (cnt == LAST_BIT) begin
                     state <= ST_HOLD;
                     cnt   <= '0;
                  end
               end
            end
            ST_HOLD:
               if (cnt == HOLD_LAST) begin
                  state         <= ST_GAP;
                  cnt           <= '0;
                  spi_csb       <= 1'b1;
                  spi_sdio_oe   <= 1'b0;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_rdata <= rw ? rd : 8'h00;
               end
            ST_GAP:
               if (cnt == GAP_LAST) begin
                  state         <= ST_IDLE;
                  bus.req_ready <= 1'b1;
                  bus.busy      <= 1'b0;
               end
            default: state <= ST_IDLE;
         endcase
      end
endmodule

// File: tb/tb_ad9511_spi_master.sv
// tb_ad9511_spi_master: directed and random AD9511 accesses against a frame/timing reference model
module tb_ad9511_spi_master;
   localparam int CS_SETUP = 2;
   localparam int CS_HOLD  = 2;
   localparam int CS_IDLE  = 4;
   localparam int RSP_K    = CS_SETUP + 48 + CS_HOLD;
   localparam int READY_K  = RSP_K + CS_IDLE - 1;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sdio_i = 1'b0;
   logic csb, sclk, sdio_o, sdio_oe;
   int n_assert = 0;
   int n_fail   = 0;
   ad9511_spi_master_if bus();
   ad9511_spi_master #(.CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)) dut (
      .clock_4MHz125(clk),
      .reset(rst),
      .bus(bus),
      .spi_csb(csb),
      .spi_sclk(sclk),
      .spi_sdio_o(sdio_o),
      .spi_sdio_oe(sdio_oe),
      .spi_sdio_i(sdio_i)
   );
   always #5 clk = ~clk;
   // AD9511 device model: captures the bit stream on SCLK rise, answers reads after the instruction
   logic [23:0] stream;
   logic [23:0] oe_bits;
   logic [7:0]  dev_byte = 8'h00;
   logic        dev_rd = 1'b0;
   int          nbits = 0;
   int          bad_sclk = 0;
   int          rsp_cnt = 0;
   always @(posedge sclk or negedge csb)
      if (sclk) begin
         if (csb) bad_sclk++;
         else begin
            if (nbits == 0) dev_rd = sdio_o;
            stream  = {stream[22:0], sdio_o};
            oe_bits = {oe_bits[22:0], sdio_oe};
            nbits++;
         end
      end else begin
         nbits   = 0;
         stream  = '0;
         oe_bits = '0;
      end
   always @(negedge sclk)
      if (!csb && dev_rd && nbits >= 16 && nbits < 24) sdio_i <= dev_byte[23-nbits];
   always @(posedge clk) if (bus.rsp_valid) rsp_cnt++;
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1);
   end
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic issue(input logic rw, input logic [12:0] a, input logic [7:0] d);
      int w = 0;
      @(negedge clk);
      while (!bus.req_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      check("ready_wait", 32'(w < 200), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_rw    = rw;
      bus.req_addr  = a;
      bus.req_wdata = d;
      @(posedge clk);
   endtask
   // observes one frame from the accept edge to the last IDLE cycle and compares with the model
   task automatic frame(input logic rw, input logic [12:0] a, input logic [7:0] d, input logic [7:0] dev,
                        input bit chain, input logic nrw, input logic [12:0] na, input logic [7:0] nd,
                        input bit toggle);
      int rsp_k = -1, rsp_n = 0, rdy_k = -1, csb_lo = 0, busy_hi = 0, oe_hi = 0;
      logic [7:0]  rdata = 8'hXX;
      logic [23:0] exp_frame = {rw, 2'b00, a, d};
      dev_byte = dev;
      for (int k = 0; k <= READY_K; k++) begin
         @(negedge clk);
         if (k == 0) begin
            if (chain) begin
               bus.req_rw    = nrw;
               bus.req_addr  = na;
               bus.req_wdata = nd;
            end else bus.req_valid = 1'b0;
         end
         if (k == 20 && toggle) begin
            bus.req_addr  = ~bus.req_addr;
            bus.req_wdata = ~bus.req_wdata;
         end
         if (bus.rsp_valid) begin
            if (rsp_n == 0) rsp_k = k;
            rsp_n++;
            rdata = bus.rsp_rdata;
         end
         if (bus.req_ready && rdy_k < 0) rdy_k = k;
         if (!csb) csb_lo++;
         if (bus.busy) busy_hi++;
         if (sdio_oe) oe_hi++;
      end
      check("rsp_cycle", 32'(rsp_k), 32'(RSP_K));
      check("rsp_pulses", 32'(rsp_n), 32'd1);
      check("rsp_rdata", 32'(rdata), 32'(rw ? dev : 8'h00));
      check("rdata_hold", 32'(bus.rsp_rdata), 32'(rw ? dev : 8'h00));
      check("ready_cycle", 32'(rdy_k), 32'(READY_K));
      check("csb_low_cycles", 32'(csb_lo), 32'(RSP_K));
      check("busy_cycles", 32'(busy_hi), 32'(READY_K));
      check("oe_cycles", 32'(oe_hi), 32'(rw ? CS_SETUP + 32 : RSP_K));
      check("sclk_rises", 32'(nbits), 32'd24);
      check("instruction", 32'(stream[23:8]), 32'(exp_frame[23:8]));
      if (!rw) check("write_data", 32'(stream[7:0]), 32'(d));
      check("oe_per_bit", 32'(oe_bits), rw ? 32'hFFFF00 : 32'hFFFFFF);
      check("sclk_while_csb_high", 32'(bad_sclk), 32'd0);
   endtask
   initial begin
      logic [12:0] a, a2;
      logic [7:0]  d, d2, v;
      logic        r;
      int          w, r0;
      bus.req_valid = 1'b0;
      bus.req_rw    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(bus.req_ready), 32'd1);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
      check("rst_csb", 32'(csb), 32'd1);
      check("rst_sclk", 32'(sclk), 32'd0);
      check("rst_sdio_o", 32'(sdio_o), 32'd0);
      check("rst_sdio_oe", 32'(sdio_oe), 32'd0);
      rst = 1'b0;
      issue(1'b0, 13'h045, 8'h02);
      frame(1'b0, 13'h045, 8'h02, 8'h00, 0, 1'b0, '0, '0, 0);
      check("write_stream", 32'(stream), 32'h004502);
      issue(1'b1, 13'h052, 8'h00);
      frame(1'b1, 13'h052, 8'h00, 8'hA5, 0, 1'b0, '0, '0, 0);
      check("read_instr", 32'(stream[23:8]), 32'h8052);
      a = 13'($urandom); d = 8'($urandom); a2 = 13'($urandom); d2 = 8'($urandom);
      issue(1'b0, a, d);
      frame(1'b0, a, d, 8'h00, 1, 1'b0, a2, d2, 0);
      frame(1'b0, a2, d2, 8'h00, 0, 1'b0, '0, '0, 0);
      a = 13'($urandom); d = 8'($urandom);
      issue(1'b0, a, d);
      @(negedge clk);
      bus.req_valid = 1'b0;
      w = 0;
      while (nbits != 11 && w < 100) begin
         @(negedge clk);
         w++;
      end
      check("reach_bit10", 32'(nbits), 32'd11);
      check("sclk_high_bit10", 32'(sclk), 32'd1);
      r0 = rsp_cnt;
      #2 rst = 1'b1;
      #1;
      check("abort_csb", 32'(csb), 32'd1);
      check("abort_sclk", 32'(sclk), 32'd0);
      check("abort_oe", 32'(sdio_oe), 32'd0);
      check("abort_ready", 32'(bus.req_ready), 32'd1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      check("abort_no_rsp", 32'(rsp_cnt), 32'(r0));
      check("abort_idle_csb", 32'(csb), 32'd1);
      v = 8'($urandom);
      issue(1'b1, 13'h1FFF, 8'h00);
      frame(1'b1, 13'h1FFF, 8'h00, v, 0, 1'b0, '0, '0, 0);
      check("read_1fff_instr", 32'(stream[23:8]), 32'h9FFF);
      a = 13'($urandom); d = 8'($urandom);
      issue(1'b0, a, d);
      frame(1'b0, a, d, 8'h00, 0, 1'b0, '0, '0, 1);
      for (int i = 0; i < 6; i++) begin
         r = 1'($urandom_range(0, 1));
         a = 13'($urandom); d = 8'($urandom); v = 8'($urandom);
         issue(r, a, r ? 8'h00 : d);
         frame(r, a, r ? 8'h00 : d, v, 0, 1'b0, '0, '0, 0);
      end
      issue(1'b0, 13'h05A, 8'h01);
      frame(1'b0, 13'h05A, 8'h01, 8'h00, 0, 1'b0, '0, '0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/ad9511_spi_master.md
# ad9511_spi_master

Serial-port master that programs and reads back the AD9511 clock distribution chip's registers. It runs directly on the 4.125 MHz programming clock derived from the 33 MHz board clock (PMCD divide-by-8). It takes one register access at a time from the board configuration sequencer and performs a single-byte AD9511 SPI transaction on CSB/SCLK/SDIO in 3-wire mode. It returns read data and a completion pulse.

## Interface
Parameters:
- CS_SETUP, 2: cycles with CSB low and SCLK low before the first SCLK rising edge.
- CS_HOLD, 2: cycles with CSB low and SCLK low after the last bit.
- CS_IDLE, 4: minimum cycles with CSB high between transactions.

Ports:
- clock_4MHz125  in  1  programming clock. Single clock for the whole block.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  access request.
- req_ready  out  1  block can accept a request. High only in IDLE.
- req_rw  in  1  1 = read, 0 = write.
- req_addr  in  13  AD9511 register address.
- req_wdata  in  8  write byte. Ignored for reads.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8  read byte. 8'h00 after a write.
- busy  out  1  high from accept until return to IDLE.
- spi_csb  out  1  chip select, active low.
- spi_sclk  out  1  serial clock, idles low.
- spi_sdio_o  out  1  SDIO output data.
- spi_sdio_oe  out  1  SDIO output enable (drives the IOBUF tristate).
- spi_sdio_i  in  1  SDIO input data.

## Operation
- Handshake: a request is accepted on the rising edge where req_valid && req_ready. Request fields are captured into a 24-bit shift register at that edge.
- Frame, MSB first: {req_rw, 2'b00 (W1:W0 = one byte), req_addr[12:0], data[7:0]}. For a read, the data byte is don't-care out.
- States:
  - IDLE → SETUP on accept.
  - SETUP → SHIFT after CS_SETUP cycles.
  - SHIFT → HOLD after 24 bits.
  - HOLD → GAP after CS_HOLD cycles. rsp_valid pulses on the HOLD→GAP edge.
  - GAP → IDLE after CS_IDLE cycles.
- SHIFT, per bit, 2 cycles:
  - Phase 0: SCLK low, sdio_o = current MSB.
  - Phase 1: SCLK high.
  - On the phase-1→0 edge, the shift register shifts and sdio_i is sampled into the read register. The sample is used only for bits 16..23 of a read.
- Output enable: spi_sdio_oe = 1 from SETUP through the end of bit 15. It then stays 1 for a write, and goes 0 for bits 16..23 and HOLD of a read. It is 0 in GAP and IDLE.
- CSB is low in SETUP, SHIFT and HOLD, and high otherwise.
- rsp_rdata is updated on the rsp_valid edge and holds its value until the next completion.
- All SPI outputs are registered; no combinational path from inputs to pins.
- Reset values: req_ready 1 (state IDLE), busy 0, rsp_valid 0, rsp_rdata 8'h00, spi_csb 1, spi_sclk 0, spi_sdio_o 0, spi_sdio_oe 0.
- Reset mid-transaction aborts immediately:
  - CSB rises and SCLK goes low asynchronously.
  - No rsp_valid is produced.
  - After reset is released, the next transaction starts from a clean frame.
- req_valid while busy is ignored; the requester must hold the request until req_ready.

## Timing
- Accept at edge T0. CSB falls at T0.
- First SCLK rise: T0 + CS_SETUP + 1.
- The 24 bits occupy 48 cycles. The last SCLK falls at T0 + CS_SETUP + 48.
- rsp_valid is high in cycle T0 + CS_SETUP + 48 + CS_HOLD. With defaults this is T0 + 52.
- CSB rises together with rsp_valid.
- req_ready returns at T0 + 52 + CS_IDLE (T0 + 56 by default). Maximum throughput is one access per 56 cycles (≈13.6 µs).
- SCLK = clock/2 ≈ 2.06 MHz, inside the AD9511 25 MHz limit.
- SDIO changes only while SCLK is low, giving at least one clock period (242 ns) of setup and hold around each SCLK rise.

## Structure
- Shared package ad9511_pkg holds:
  - State enum.
  - Frame field constants: RW bit position, W1W0 = 2'b00, frame length 24, instruction length 16.
  - Named register addresses used by the sequencer, including 13'h05A (update registers).
- No sub-module: one FSM, one 6-bit cycle/bit counter, one 24-bit shift register and one 8-bit read register fit in a single module.
- The IOBUF for SDIO stays at the top level.

## Test plan
- Write addr 13'h045, data 8'h02:
  - Captured bit stream is 24'h004502.
  - Exactly 24 SCLK rises.
  - oe high throughout.
  - rsp_valid at T0+52 with rsp_rdata 8'h00.
- Read addr 13'h052, device model drives 8'hA5:
  - Instruction bits are 16'h8052.
  - oe falls after bit 15.
  - rsp_rdata = 8'hA5 at T0+52.
- req_valid held high for two back-to-back writes:
  - Second accept at T0+56.
  - CSB high for exactly 4 cycles between frames.
  - No SCLK activity while CSB is high.
- Reset asserted during bit 10 of a write:
  - CSB goes high and SCLK low without waiting for a clock edge.
  - No rsp_valid.
  - A following read of 13'h1FFF shows instruction 16'h9FFF and completes normally.
- Request field changes after accept (addr and data toggled during SHIFT): the frame is unaffected and busy stays high until T0+56.
